uart_rx_parity: RTL and testbench

- Serial receiver that consumes the line driven by the team's UART transmitter.
- Frame format: idle 1, start 0, 8 data bits LSB first, even parity bit, 1 stop bit.
- Oversamples the asynchronous line with the system clock, recovers each byte, and presents it with error flags on a valid/ready interface to the downstream consumer.

---
 rtl/uart_rx_parity_if.sv | 14 +
 rtl/uart_rx_parity.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_parity.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_parity_if.sv
// Receive-side byte interface of uart_rx_parity: received byte, error flags
// and the valid/ready handshake toward the downstream consumer.
interface uart_rx_parity_if;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       parity_err;
   logic       frame_err;
   logic       overrun;

   // The receiver produces the byte; the consumer drives ready.
   modport master (output data, valid, parity_err, frame_err, overrun, input ready);
   modport slave  (input  data, valid, parity_err, frame_err, overrun, output ready);
endinterface

// File: rtl/uart_rx_parity.sv
// UART receiver: 8 data bits LSB first, even parity, 1 stop bit.
// Oversamples the line with clk, recovers each byte and delivers it with
// parity/frame/overrun flags on a valid/ready interface.
// Optional macro UART_RX_MAJORITY_EN: each bit decision becomes a 2-of-3
// majority of three consecutive samples around mid-bit, decided one cycle
// later (requires CLKS_PER_BIT >= 6).
module uart_rx_parity #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             line,
   output logic             busy,
   uart_rx_parity_if.master rx
);
   localparam int MID = CLKS_PER_BIT / 2;
   localparam int CW  = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
   localparam logic [CW-1:0] C_START = CW'(MID);
`else
   localparam logic [CW-1:0] C_START = CW'(MID - 1);
`endif

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   logic          r_sync1, r_sync2;
   logic          w_rxs;
   logic          w_bit;
   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [2:0]    r_idx, w_idx_nxt;
   logic [7:0]    r_shift, w_shift_nxt;
   logic          r_perr, w_perr_nxt;
   logic          r_armed, w_armed_nxt;
   logic          r_dlv, w_dlv_nxt;
   logic          r_dlv_ferr, w_dlv_ferr_nxt;

   assign w_rxs = r_sync2;

   // Two-flop synchronizer for the asynchronous line; idles high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= line;
         r_sync2 <= r_sync1;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] r_hist;

   // Keep the two previous rxs samples so the decision cycle sees three in a row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_hist <= 2'b11;
      else        r_hist <= {r_hist[0], w_rxs};
   end

   assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rxs) | (r_hist[0] & w_rxs);
`else
   assign w_bit = w_rxs;
`endif

   // FSM and datapath state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_shift    <= '0;
         r_perr     <= 1'b0;
         r_armed    <= 1'b1;
         r_dlv      <= 1'b0;
         r_dlv_ferr <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_idx      <= w_idx_nxt;
         r_shift    <= w_shift_nxt;
         r_perr     <= w_perr_nxt;
         r_armed    <= w_armed_nxt;
         r_dlv      <= w_dlv_nxt;
         r_dlv_ferr <= w_dlv_ferr_nxt;
      end
   end

   // Next-state: bit-period timing, bit capture, parity and stop evaluation.
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt + CW'(1);
      w_idx_nxt      = r_idx;
      w_shift_nxt    = r_shift;
      w_perr_nxt     = r_perr;
      w_armed_nxt    = r_armed;
      w_dlv_nxt      = 1'b0;
      w_dlv_ferr_nxt = r_dlv_ferr;
      unique case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            // A frame that ended in a low stop bit must see the line high
            // again before another start edge is accepted.
            if (w_rxs)        w_armed_nxt = 1'b1;
            else if (r_armed) w_state_nxt = S_START;
         end
         S_START: begin
            if (r_cnt == C_START) begin
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
               w_state_nxt = w_bit ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (r_cnt == C_LAST) begin
               w_cnt_nxt          = '0;
               w_shift_nxt[r_idx] = w_bit;
               w_idx_nxt          = r_idx + 3'd1;
               if (r_idx == 3'd7) w_state_nxt = S_PARITY;
            end
         end
         S_PARITY: begin
            if (r_cnt == C_LAST) begin
               w_cnt_nxt   = '0;
               w_perr_nxt  = ^{r_shift, w_bit};
               w_state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            // Return to idle at the stop sample so a following start edge
            // arriving early in the stop bit's second half is not missed.
            if (r_cnt == C_LAST) begin
               w_cnt_nxt      = '0;
               w_state_nxt    = S_IDLE;
               w_dlv_nxt      = 1'b1;
               w_dlv_ferr_nxt = ~w_bit;
               if (!w_bit) w_armed_nxt = 1'b0;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign busy = (r_state != S_IDLE);

   // Output register: load on delivery (always overwrites), clear on handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx.data       <= '0;
         rx.valid      <= 1'b0;
         rx.parity_err <= 1'b0;
         rx.frame_err  <= 1'b0;
         rx.overrun    <= 1'b0;
      end else if (r_dlv) begin
         rx.data       <= r_shift;
         rx.parity_err <= r_perr;
         rx.frame_err  <= r_dlv_ferr;
         rx.valid      <= 1'b1;
         rx.overrun    <= rx.valid && !rx.ready;
      end else if (rx.valid && rx.ready) begin
         rx.valid   <= 1'b0;
         rx.overrun <= 1'b0;
      end
   end
endmodule

// File: tb/tb_uart_rx_parity.sv
// Self-checking bench for uart_rx_parity: a transaction-level model predicts
// delivery time, byte, flags and busy windows from each frame sent; a
// per-cycle compare process checks the DUT against it, and directed checks
// pin hand-computed values.
module tb_uart_rx_parity;
   localparam int C   = 16;
   localparam int MID = C / 2;
`ifdef UART_RX_MAJORITY_EN
   localparam int D       = 1;
   localparam int LAT_LIT = 172;
`else
   localparam int D       = 0;
   localparam int LAT_LIT = 171;
`endif
   localparam int LAT = 2 + MID + 10 * C + 1 + D;

   logic clk = 1'b0;
   logic rst_n;
   logic line;
   logic busy;
   uart_rx_parity_if rx_if();

   uart_rx_parity #(.CLKS_PER_BIT(C)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .line  (line),
      .busy  (busy),
      .rx    (rx_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   typedef struct {int due; logic [7:0] d; logic pe; logic fe;} exp_t;
   typedef struct {int lo; int hi;} win_t;
   exp_t pend[$];
   win_t wins[$];
   int   cyc = 0;
   logic       m_valid = 0, m_pe = 0, m_fe = 0, m_ov = 0;
   logic [7:0] m_data = 0;

   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         pend.delete();
         wins.delete();
         m_valid = 0; m_data = 0; m_pe = 0; m_fe = 0; m_ov = 0;
      end else if (pend.size() > 0 && pend[0].due == cyc) begin
         m_ov    = m_valid && !rx_if.ready;
         m_valid = 1;
         m_data  = pend[0].d;
         m_pe    = pend[0].pe;
         m_fe    = pend[0].fe;
         void'(pend.pop_front());
      end else if (m_valid && rx_if.ready) begin
         m_valid = 0;
         m_ov    = 0;
      end
   end

   // ---------------- compare ----------------
   logic       prev_v = 0;
   int         cap_n = 0, cap_cyc = 0, busy_hi = 0;
   logic [7:0] cap_data = 0;
   logic       cap_pe = 0, cap_fe = 0, cap_ov = 0;

   always @(negedge clk) begin
      logic eb;
      eb = 0;
      foreach (wins[i]) if (cyc >= wins[i].lo && cyc < wins[i].hi) eb = 1;
      chk("valid", rx_if.valid, m_valid);
      chk("busy", busy, eb);
      if (m_valid || !rst_n) begin
         chk("data", rx_if.data, m_data);
         chk("parity_err", rx_if.parity_err, m_pe);
         chk("frame_err", rx_if.frame_err, m_fe);
         chk("overrun", rx_if.overrun, m_ov);
      end
      if (busy) busy_hi++;
      if (rx_if.valid && !prev_v) begin
         cap_n++;
         cap_cyc  = cyc;
         cap_data = rx_if.data;
         cap_pe   = rx_if.parity_err;
         cap_fe   = rx_if.frame_err;
         cap_ov   = rx_if.overrun;
      end
      prev_v = rx_if.valid;
   end

   // ---------------- stimulus ----------------
   int last_start = 0;

   task automatic hold_line(input logic v, input int n);
      repeat (n) begin
         @(negedge clk); #1;
         line = v;
      end
   endtask

   // Drives one frame; glitch_j forces the pin high for that one cycle,
   // rst_j asserts reset at that cycle and abandons the frame.
   task automatic drive_frame(input logic [7:0] d, input logic bad_par, input logic stop_b,
                              input int glitch_j, input int rst_j);
      logic [10:0] bits;
      exp_t e;
      win_t w;
      bits = {stop_b, (^d) ^ bad_par, d, 1'b0};
      for (int j = 0; j < 11 * C; j++) begin
         @(negedge clk); #1;
         if (j == 0) begin
            last_start = cyc;
            e.due = cyc + 1 + LAT; e.d = d; e.pe = bad_par; e.fe = ~stop_b;
            pend.push_back(e);
            w.lo = cyc + 3; w.hi = cyc + 3 + MID + 10 * C + D;
            wins.push_back(w);
         end
         if (j == rst_j) begin
            rst_n = 0;
            line  = 1;
            @(negedge clk);
            chk("midrst_valid", rx_if.valid, 1'b0);
            chk("midrst_busy", busy, 1'b0);
            chk("midrst_data", rx_if.data, 8'h00);
            repeat (2) @(negedge clk);
            #1 rst_n = 1;
            return;
         end
         line = (j == glitch_j) ? 1'b1 : bits[j / C];
      end
   endtask

   initial begin
      int n0, b0;
      win_t w;
      rst_n = 0; line = 1; rx_if.ready = 1;
      repeat (4) @(negedge clk);
      chk("rst_valid", rx_if.valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_data", rx_if.data, 8'h00);
      chk("rst_flags", {rx_if.parity_err, rx_if.frame_err, rx_if.overrun}, 3'b000);
      #1 rst_n = 1;
      hold_line(1, 2 * C);

      // Good 0xA5.
      drive_frame(8'hA5, 0, 1, -1, -1);
      hold_line(1, 2 * C);
      chk("a5_pulses", cap_n, 1);
      chk("a5_data", cap_data, 8'hA5);
      chk("a5_flags", {cap_pe, cap_fe, cap_ov}, 3'b000);
      chk("a5_latency", cap_cyc - last_start - 1, LAT_LIT);

      // 0x01 with wrong parity bit (0).
      drive_frame(8'h01, 1, 1, -1, -1);
      hold_line(1, 2 * C);
      chk("p01_data", cap_data, 8'h01);
      chk("p01_flags", {cap_pe, cap_fe}, 2'b10);

      // 0x3C with low stop bit, then a 40-bit break, then clean 0x55.
      drive_frame(8'h3C, 0, 0, -1, -1);
      n0 = cap_n;
      chk("fe_data", cap_data, 8'h3C);
      chk("fe_flags", {cap_pe, cap_fe}, 2'b01);
      hold_line(0, 40 * C);
      hold_line(1, 2 * C);
      chk("break_no_frames", cap_n, n0);
      drive_frame(8'h55, 0, 1, -1, -1);
      hold_line(1, 2 * C);
      chk("b55_data", cap_data, 8'h55);
      chk("b55_flags", {cap_pe, cap_fe, cap_ov}, 3'b000);

      // 4-cycle glitch: false start.
      n0 = cap_n;
      b0 = busy_hi;
      @(negedge clk); #1;
      w.lo = cyc + 3; w.hi = cyc + 3 + MID + D;
      wins.push_back(w);
      line = 0;
      hold_line(0, 3);
      hold_line(1, 2 * C);
      chk("glitch_no_valid", cap_n, n0);
      chk("glitch_busy_len", busy_hi - b0, 8 + D);

      // Back-to-back with ready low: overrun.
      rx_if.ready = 0;
      drive_frame(8'h11, 0, 1, -1, -1);
      drive_frame(8'h22, 0, 1, -1, -1);
      hold_line(1, 2 * C);
      chk("ovr_valid", rx_if.valid, 1'b1);
      chk("ovr_data", rx_if.data, 8'h22);
      chk("ovr_flag", rx_if.overrun, 1'b1);
      @(negedge clk); #1 rx_if.ready = 1;
      @(negedge clk);
      chk("ovr_acc_valid", rx_if.valid, 1'b0);
      chk("ovr_acc_flag", rx_if.overrun, 1'b0);
      hold_line(1, C);

      // Reset in the middle of 0xFF data, then 0x80.
      n0 = cap_n;
      drive_frame(8'hFF, 0, 1, -1, 4 * C);
      hold_line(1, C);
      drive_frame(8'h80, 0, 1, -1, -1);
      hold_line(1, 2 * C);
      chk("rst_only_80", cap_n, n0 + 1);
      chk("rst_80_data", cap_data, 8'h80);

`ifdef UART_RX_MAJORITY_EN
      // One-cycle high glitch at the centre of data bit 3 of 0x00.
      n0 = cap_n;
      drive_frame(8'h00, 0, 1, 4 * C + MID, -1);
      hold_line(1, 2 * C);
      chk("maj_count", cap_n, n0 + 1);
      chk("maj_data", cap_data, 8'h00);
      chk("maj_perr", cap_pe, 1'b0);
`endif

      chk("all_delivered", pend.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
